// File: rtl/matrix_result_reader.sv
// Captures one product vector from Matrix_Mul and replays it over valid/ready.
// Define RESULT_SUM_EN to append a wrapping sum beat after the last element.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module matrix_result_reader #(
  parameter int unsigned WORD_SIZE = `WORD_SIZE,
  parameter int unsigned VEC_LEN   = 8
) (
  input  logic                        src_clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [WORD_SIZE-1:0] in_data,
  input  logic [3:0]                  in_qi,
  input  logic [3:0]                  in_qf,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [WORD_SIZE-1:0] out_data,
  output logic [$clog2(VEC_LEN):0]    out_idx,
  output logic                        out_last,
  output logic [3:0]                  qi,
  output logic [3:0]                  qf,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned AW = $clog2(VEC_LEN);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LastWr = CW'(VEC_LEN - 1);
`ifdef RESULT_SUM_EN
  localparam logic [CW-1:0] LastRd = CW'(VEC_LEN);
`else
  localparam logic [CW-1:0] LastRd = CW'(VEC_LEN - 1);
`endif

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               wcnt_q, wcnt_d;
  logic [CW-1:0]               rcnt_q, rcnt_d;
  logic                        err_q, err_d;
  logic                        busy_q;
  logic [3:0]                  qi_q, qf_q;
  logic                        mem_we;
  logic [AW-1:0]               mem_waddr;
  logic                        cap_first;
  logic signed [WORD_SIZE-1:0] mem_q [VEC_LEN];

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = wcnt_q[AW-1:0];
    cap_first = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          cap_first = 1'b1;
          wcnt_d    = CW'(1);
          state_d   = StCollect;
        end
      end
      StCollect: begin
        if (in_valid) begin
          mem_we = 1'b1;
          wcnt_d = wcnt_q + CW'(1);
          if (wcnt_q == LastWr) begin
            rcnt_d  = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Input arriving while draining has nowhere to go; flag it and drop it.
        if (in_valid) begin
          err_d = 1'b1;
        end
        if (out_ready) begin
          if (rcnt_q == LastRd) begin
            rcnt_d  = '0;
            state_d = StIdle;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      qi_q    <= '0;
      qf_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
      busy_q  <= (state_d != StIdle);
      if (cap_first) begin
        qi_q <= in_qi;
        qf_q <= in_qf;
      end
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge src_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= in_data;
    end
  end

`ifdef RESULT_SUM_EN
  logic signed [WORD_SIZE-1:0] sum_q;

  // Element 0 restarts the accumulation; the sum wraps without saturation.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (cap_first) begin
      sum_q <= in_data;
    end else if (mem_we) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

  always_comb begin
    out_data = '0;
    if (state_q == StDrain) begin
`ifdef RESULT_SUM_EN
      if (rcnt_q == CW'(VEC_LEN)) begin
        out_data = sum_q;
      end else begin
        out_data = mem_q[rcnt_q[AW-1:0]];
      end
`else
      out_data = mem_q[rcnt_q[AW-1:0]];
`endif
    end
  end

  assign out_valid = (state_q == StDrain);
  assign out_idx   = out_valid ? rcnt_q : '0;
  assign out_last  = out_valid && (rcnt_q == LastRd);
  assign qi        = qi_q;
  assign qf        = qf_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
